// File: rtl/neuron_grid_pkg.sv
// Shared sizing and FSM encoding for the spike scheduler and neuron grid.
package neuron_grid_pkg;
  localparam int NUM_AXONS = 256;
  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic {IDLE = 1'b0, ADVANCE = 1'b1} state_t;
endpackage

// File: rtl/spike_slot_mem.sv
// Delay-ring storage: NUM_SLOTS rows of NUM_AXONS spike bits with one set port,
// one row-clear port and a combinational row read port.
module spike_slot_mem #(
  parameter  int NUM_AXONS = neuron_grid_pkg::NUM_AXONS,
  parameter  int NUM_SLOTS = neuron_grid_pkg::NUM_SLOTS,
  localparam int SW        = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [SW-1:0]        set_slot,
  input  logic [7:0]           set_axon,
  input  logic                 clr_en,
  input  logic [SW-1:0]        clr_slot,
  input  logic [SW-1:0]        rd_slot,
  output logic [NUM_AXONS-1:0] rd_data
);
  logic [NUM_AXONS-1:0] rows [NUM_SLOTS];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic [NUM_AXONS-1:0] row;

    // Set is applied after clear so a same-row set survives (never happens with legal delays).
    always_ff @(posedge clk or posedge reset) begin
      if (reset) row <= '0;
      else begin
        if (clr_en && clr_slot == SW'(g)) row <= '0;
        if (set_en && set_slot == SW'(g)) row[set_axon] <= 1'b1;
      end
    end

    assign rows[g] = row;
  end

  assign rd_data = rows[rd_slot];
endmodule

// File: rtl/spike_scheduler.sv
// Timestep-delayed spike delivery ring feeding neuron_grid.
// Optional SPIKE_SCHED_DROP_CNT_EN adds a saturating drop_cnt output.
module spike_scheduler
  import neuron_grid_pkg::state_t, neuron_grid_pkg::IDLE, neuron_grid_pkg::ADVANCE;
#(
  parameter  int NUM_AXONS = neuron_grid_pkg::NUM_AXONS,
  parameter  int NUM_SLOTS = neuron_grid_pkg::NUM_SLOTS,
  localparam int SW        = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 evt_valid,
  output logic                 evt_ready,
  input  logic [7:0]           evt_axon,
  input  logic [3:0]           evt_delay,
  input  logic                 scheduler_clr,
  output logic [NUM_AXONS-1:0] axon_spikes,
  output logic                 axon_valid,
  output logic                 error
`ifdef SPIKE_SCHED_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);
  state_t               state;
  logic [SW-1:0]        rd_ptr;
  logic [NUM_AXONS-1:0] rd_data;
  logic                 accept, set_en, clr_en, bad_evt, missed_tick;
  logic [SW-1:0]        set_slot;

  assign evt_ready   = (state == IDLE) & ~tick & ~reset;
  assign accept      = evt_valid & evt_ready;
  assign bad_evt     = accept & (evt_delay == 4'd0);
  assign set_en      = accept & (evt_delay != 4'd0);
  // Ring arithmetic wraps naturally in the slot-index width.
  assign set_slot    = rd_ptr + SW'(evt_delay);
  assign clr_en      = (state == IDLE) & scheduler_clr;
  assign missed_tick = (state == ADVANCE) & tick;

  spike_slot_mem #(.NUM_AXONS(NUM_AXONS), .NUM_SLOTS(NUM_SLOTS)) u_mem (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_slot (set_slot),
    .set_axon (evt_axon),
    .clr_en   (clr_en),
    .clr_slot (rd_ptr),
    .rd_slot  (rd_ptr),
    .rd_data  (rd_data)
  );

  // Clear targets the pre-increment rd_ptr, so clr+tick clears the old slot then advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      axon_spikes <= '0;
      axon_valid  <= 1'b0;
      error       <= 1'b0;
    end else begin
      axon_valid <= 1'b0;
      error      <= bad_evt | missed_tick;
      case (state)
        IDLE: if (tick) begin
          rd_ptr <= rd_ptr + 1'b1;
          state  <= ADVANCE;
        end
        ADVANCE: begin
          axon_spikes <= rd_data;
          axon_valid  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_SCHED_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          drop_cnt <= '0;
    else if (error && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_spike_scheduler.sv
// Directed self-checking bench for spike_scheduler (default 256 axons, 16 slots).
module tb_spike_scheduler;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0;
  logic         evt_valid = 1'b0;
  logic         evt_ready;
  logic [7:0]   evt_axon = '0;
  logic [3:0]   evt_delay = '0;
  logic         scheduler_clr = 1'b0;
  logic [255:0] axon_spikes;
  logic         axon_valid;
  logic         error;
`ifdef SPIKE_SCHED_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  int total = 0;
  int passed = 0;

  spike_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_axon      (evt_axon),
    .evt_delay     (evt_delay),
    .scheduler_clr (scheduler_clr),
    .axon_spikes   (axon_spikes),
    .axon_valid    (axon_valid),
    .error         (error)
`ifdef SPIKE_SCHED_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick = 1'b0; evt_valid = 1'b0; scheduler_clr = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_evt(input logic [7:0] a, input logic [3:0] d);
    evt_axon = a; evt_delay = d; evt_valid = 1'b1;
    step();
    evt_valid = 1'b0;
  endtask

  // Tick then wait for the ADVANCE load; returns with the new axon_spikes visible.
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    evt_valid = 1'b1;
    #3;
    total++;
    if (evt_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", evt_ready); else passed++;
    evt_valid = 1'b0;
    step();
    total++;
    if (axon_spikes !== '0 || axon_valid !== 1'b0 || error !== 1'b0)
      $display("FAIL reset_outputs: got spikes=%h valid=%b err=%b want 0/0/0", axon_spikes, axon_valid, error);
    else passed++;
`ifdef SPIKE_SCHED_DROP_CNT_EN
    total++;
    if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); else passed++;
`endif
    reset = 1'b0;
    #1;
    total++;
    if (evt_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", evt_ready); else passed++;
  endtask

  task automatic test_basic();
    logic [255:0] exp;
    do_reset();
    send_evt(8'd5, 4'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    total++;
    if (evt_ready !== 1'b0 || axon_valid !== 1'b0)
      $display("FAIL basic_advance: got ready=%b valid=%b want 0/0", evt_ready, axon_valid);
    else passed++;
    step();
    exp = '0; exp[5] = 1'b1;
    total++;
    if (axon_spikes !== exp || axon_valid !== 1'b1)
      $display("FAIL basic_deliver: got %h valid=%b want %h valid=1", axon_spikes, axon_valid, exp);
    else passed++;
    step();
    total++;
    if (axon_valid !== 1'b0) $display("FAIL basic_valid_once: got %b want 0", axon_valid); else passed++;
  endtask

  task automatic test_wrap();
    logic [255:0] exp;
    do_reset();
    for (int i = 0; i < 14; i++) do_tick();
    send_evt(8'd200, 4'd3);
    for (int t = 1; t <= 2; t++) begin
      do_tick();
      total++;
      if (axon_spikes[200] !== 1'b0) $display("FAIL wrap_early_%0d: got bit200=%b want 0", t, axon_spikes[200]);
      else passed++;
    end
    do_tick();
    exp = '0; exp[200] = 1'b1;
    total++;
    if (axon_spikes !== exp || axon_valid !== 1'b1)
      $display("FAIL wrap_deliver: got %h valid=%b want %h valid=1", axon_spikes, axon_valid, exp);
    else passed++;
  endtask

  task automatic test_illegal_delay();
    int bad;
    do_reset();
    send_evt(8'd9, 4'd0);
    total++;
    if (error !== 1'b1) $display("FAIL illegal_error: got %b want 1", error); else passed++;
    step();
    total++;
    if (error !== 1'b0) $display("FAIL illegal_error_once: got %b want 0", error); else passed++;
`ifdef SPIKE_SCHED_DROP_CNT_EN
    total++;
    if (drop_cnt !== 16'd1) $display("FAIL illegal_drop_cnt: got %0d want 1", drop_cnt); else passed++;
`endif
    bad = 0;
    for (int t = 0; t < 16; t++) begin
      do_tick();
      if (axon_spikes !== '0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL illegal_storage: got %0d nonzero slots want 0", bad); else passed++;
  endtask

  task automatic test_missed_tick();
    logic [255:0] exp;
    do_reset();
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    total++;
    if (error !== 1'b1 || axon_valid !== 1'b1)
      $display("FAIL missed_tick: got err=%b valid=%b want 1/1", error, axon_valid);
    else passed++;
    // rd_ptr must be 1, so delay 1 lands in slot 2 and shows on the next tick
    send_evt(8'd3, 4'd1);
    do_tick();
    exp = '0; exp[3] = 1'b1;
    total++;
    if (axon_spikes !== exp) $display("FAIL missed_tick_ptr: got %h want %h", axon_spikes, exp); else passed++;
  endtask

  task automatic test_clr_and_tick();
    logic [255:0] exp;
    do_reset();
    send_evt(8'd7, 4'd1);
    do_tick();
    exp = '0; exp[7] = 1'b1;
    total++;
    if (axon_spikes !== exp) $display("FAIL clr_setup: got %h want %h", axon_spikes, exp); else passed++;
    send_evt(8'd4, 4'd1);
    scheduler_clr = 1'b1;
    tick = 1'b1;
    step();
    scheduler_clr = 1'b0;
    tick = 1'b0;
    step();
    exp = '0; exp[4] = 1'b1;
    total++;
    if (axon_spikes !== exp) $display("FAIL clr_new_slot: got %h want %h", axon_spikes, exp); else passed++;
    for (int t = 0; t < 15; t++) do_tick();
    total++;
    if (axon_spikes !== '0 || axon_valid !== 1'b1)
      $display("FAIL clr_old_slot: got %h valid=%b want 0 valid=1", axon_spikes, axon_valid);
    else passed++;
  endtask

  task automatic test_handshake();
    logic [255:0] exp;
    do_reset();
    evt_axon = 8'd10; evt_delay = 4'd2; evt_valid = 1'b1;
    tick = 1'b1;
    #1;
    total++;
    if (evt_ready !== 1'b0) $display("FAIL hs_tick_cycle: got %b want 0", evt_ready); else passed++;
    step();
    tick = 1'b0;
    #1;
    total++;
    if (evt_ready !== 1'b0) $display("FAIL hs_advance: got %b want 0", evt_ready); else passed++;
    step();
    total++;
    if (evt_ready !== 1'b1) $display("FAIL hs_idle: got %b want 1", evt_ready); else passed++;
    step();
    evt_valid = 1'b0;
    do_tick();
    total++;
    if (axon_spikes[10] !== 1'b0) $display("FAIL hs_not_old_ptr: got bit10=%b want 0", axon_spikes[10]); else passed++;
    do_tick();
    exp = '0; exp[10] = 1'b1;
    total++;
    if (axon_spikes !== exp) $display("FAIL hs_new_ptr: got %h want %h", axon_spikes, exp); else passed++;
  endtask

  task automatic test_reset_mid_advance();
    logic [255:0] exp;
    int bad;
    do_reset();
    send_evt(8'd1, 4'd1);
    send_evt(8'd2, 4'd2);
    do_tick();
    exp = '0; exp[1] = 1'b1;
    total++;
    if (axon_spikes !== exp) $display("FAIL rst_setup: got %h want %h", axon_spikes, exp); else passed++;
    tick = 1'b1;
    step();
    tick = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (axon_spikes !== '0 || evt_ready !== 1'b0 || axon_valid !== 1'b0)
      $display("FAIL rst_abort: got spikes=%h ready=%b valid=%b want 0/0/0", axon_spikes, evt_ready, axon_valid);
    else passed++;
    step();
    reset = 1'b0;
    bad = 0;
    for (int t = 0; t < 16; t++) begin
      do_tick();
      if (axon_spikes !== '0 || axon_valid !== 1'b1) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL rst_slots_empty: got %0d bad deliveries want 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_illegal_delay();
    test_missed_tick();
    test_clr_and_tick();
    test_handshake();
    test_reset_mid_advance();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/spike_scheduler.md
SPIKE_SCHEDULER -- requirements
Module: spike_scheduler

Interface
REQ-001 Parameter NUM_AXONS, default 256, width of the axon spike vector handed to neuron_grid.
REQ-002 Parameter NUM_SLOTS, default 16, number of delay slots in the ring; a power of two.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle global timestep pulse, shared with neuron_grid.
REQ-006 evt_valid  input  1  incoming spike event valid.
REQ-007 evt_ready  output  1  event accepted on any cycle with evt_valid & evt_ready.
REQ-008 evt_axon  input  8  destination axon index.
REQ-009 evt_delay  input  4  delivery delay in ticks; legal range 1..15.
REQ-010 scheduler_clr  input  1  from neuron_grid; clears the current read slot.
REQ-011 axon_spikes  output  NUM_AXONS  registered contents of the current read slot, feeding neuron_grid.
REQ-012 axon_valid  output  1  one-cycle pulse when axon_spikes has been reloaded.
REQ-013 error  output  1  one-cycle pulse on a dropped event or a missed tick.

Function
REQ-014 Storage SHALL be NUM_SLOTS x NUM_AXONS bits, plus a read pointer rd_ptr of log2(NUM_SLOTS) bits.
REQ-015 The FSM SHALL have exactly two states, IDLE and ADVANCE.
REQ-016 evt_ready SHALL equal (state==IDLE) & ~tick.
REQ-017 Accepted event with evt_delay != 0: set bit evt_axon of slot (rd_ptr + evt_delay) mod NUM_SLOTS on the same edge.
REQ-018 Target-slot arithmetic SHALL be 4-bit, so wrap-around is implicit.
REQ-019 Accepted event with evt_delay == 0: drop it, leave storage unchanged, pulse error the next cycle.
REQ-020 Setting an already-set bit SHALL be harmless; it leaves the bit set and raises no error.
REQ-021 In IDLE, scheduler_clr SHALL zero slot[rd_ptr] on that edge; axon_spikes is unchanged.
REQ-022 In IDLE, tick SHALL increment rd_ptr (mod NUM_SLOTS) and move the FSM to ADVANCE.
REQ-023 If scheduler_clr and tick are high in the same IDLE cycle, the old slot SHALL be cleared first and rd_ptr then advanced.
REQ-024 In ADVANCE: load axon_spikes <= slot[rd_ptr], pulse axon_valid, return to IDLE.
REQ-025 axon_spikes SHALL therefore be updated 2 cycles after the tick edge.
REQ-026 tick or scheduler_clr arriving in ADVANCE SHALL be ignored; a tick there also pulses error next cycle.
REQ-027 Since evt_delay <= 15 < NUM_SLOTS, no event SHALL ever target the slot currently being read.

Reset
REQ-028 On reset: all slots = 0, rd_ptr = 0, axon_spikes = 0, axon_valid = 0, error = 0, state = IDLE.
REQ-029 Reset asserted mid-operation (including during ADVANCE) SHALL abort immediately; pending events are lost.
REQ-030 evt_ready SHALL be 0 while reset is high.

Configuration
REQ-031 Macro SPIKE_SCHED_DROP_CNT_EN defined: add output drop_cnt, 16 bits.
REQ-032 drop_cnt SHALL increment on every error pulse, saturate at 16'hFFFF, and reset to 0.
REQ-033 Macro not defined: no drop_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-034 Shared package neuron_grid_pkg SHALL hold NUM_AXONS, NUM_SLOTS, the slot-index width, and the state enum {IDLE, ADVANCE}.
REQ-035 One sub-module spike_slot_mem SHALL hold the slot array with ports: set (slot, axon), clear (slot), and read (slot).
REQ-036 The FSM and pointer logic SHALL reside in spike_scheduler.

Verification
REQ-037 Basic delivery: reset, then event axon=5 delay=1, then tick -> at tick+2 cycles, axon_spikes[5]=1, all other bits 0, axon_valid pulses once.
REQ-038 Wrap-around: rd_ptr=14, event axon=200 delay=3 -> appears after exactly 3 ticks (slot 1); no earlier axon_spikes shows bit 200.
REQ-039 Illegal delay: event delay=0 -> error pulses once, storage unchanged; drop_cnt=1 with SPIKE_SCHED_DROP_CNT_EN.
REQ-040 Simultaneous clr and tick: slot[rd_ptr] holding bit 7, both asserted -> old slot is zero when revisited 16 ticks later; new slot loaded normally.
REQ-041 Handshake: evt_valid held high across a tick -> evt_ready low in the tick cycle and in ADVANCE; event accepted in the first IDLE cycle after, relative to the new rd_ptr.
REQ-042 Reset mid-ADVANCE: assert reset -> axon_spikes = 0 and all slots empty; a subsequent tick delivers all zeros.
